// File: rtl/jk_bank_pkg.sv
// Shared types and the JK bank update rule for the JK bank arbiter.
package jk_bank_pkg;

  // Widest bank the shared update function handles; callers zero-extend.
  localparam int JK_MAX_W = 64;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [JK_MAX_W-1:0] jk_apply(
    input logic [JK_MAX_W-1:0] q,
    input jk_cmd_t             cmd,
    input logic [JK_MAX_W-1:0] mask
  );
    logic [JK_MAX_W-1:0] nxt;
    case (cmd)
      JK_CLR:  nxt = q & ~mask;
      JK_SET:  nxt = q | mask;
      JK_TGL:  nxt = q ^ mask;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import jk_bank_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Two passes give the wrap: [ptr, NUM_REQ) first, then [0, ptr).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop bank between requesters, with bank locking.
// Optional stall counter output enabled by defining JK_BANK_ARBITER_STATS_EN.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = 8,
  parameter  int LOCK_MAX = 16,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_jk,
  input  logic [WIDTH*NUM_REQ-1:0] req_mask,
  input  logic [NUM_REQ-1:0]       req_lock,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         q,
  output logic [IDX_W-1:0]         owner,
  output logic                     busy
`ifdef JK_BANK_ARBITER_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [WIDTH-1:0]    bank_q, bank_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  jk_cmd_t             xfer_cmd;
  logic [WIDTH-1:0]    xfer_mask;
  logic                xfer_lock;
  logic                lock_expired;
  logic [JK_MAX_W-1:0] bank_ext, mask_ext, bank_nxt;
  logic                unused_bank_hi;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // While locked only the owner can be served; reset suppresses every grant.
  always_comb begin
    grant = '0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        grant = pick_gnt;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          grant[i] = (owner_q == IDX_W'(i)) && req_valid[i];
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    xfer_cmd  = JK_HOLD;
    xfer_mask = '0;
    xfer_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        xfer_cmd  = jk_cmd_t'(req_jk[2*i +: 2]);
        xfer_mask = req_mask[WIDTH*i +: WIDTH];
        xfer_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    bank_ext = '0;
    mask_ext = '0;
    bank_ext[WIDTH-1:0] = bank_q;
    mask_ext[WIDTH-1:0] = xfer_mask;
    bank_nxt = jk_apply(bank_ext, xfer_cmd, mask_ext);
  end

  // Bits of the shared update above WIDTH are never consumed.
  assign unused_bank_hi = ^bank_nxt;

  assign lock_expired = (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    bank_d     = bank_q;
    if (xfer) begin
      bank_d = bank_nxt[WIDTH-1:0];
    end
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          owner_d  = pick_idx;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (xfer_lock) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        // rr_ptr already points past the owner from the locking transfer.
        lock_cnt_d = lock_cnt_q + 1'b1;
        if ((xfer && !xfer_lock) || lock_expired) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      bank_q     <= bank_d;
    end
  end

  assign q     = bank_q;
  assign owner = owner_q;
  assign busy  = (state_q == ST_LOCKED);

`ifdef JK_BANK_ARBITER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // A cycle stalls when some valid requester is left without a transfer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(req_valid & ~grant)) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_jk_bank_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int LM = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [2*NR-1:0]   req_jk;
  logic [W*NR-1:0]   req_mask;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     req_ready;
  logic [W-1:0]      q;
  logic [1:0]        owner;
  logic              busy;
`ifdef JK_BANK_ARBITER_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_jk    (req_jk),
    .req_mask  (req_mask),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .q         (q),
    .owner     (owner),
    .busy      (busy)
`ifdef JK_BANK_ARBITER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [NR-1:0] ready;
    logic [W-1:0]  q;
    int            owner;
    bit            busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state: the bank, pointer, owner and lock bookkeeping.
  bit [W-1:0] m_q;
  int         m_ptr;
  int         m_owner;
  bit         m_locked;
  int         m_cnt;
  bit         m_known = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decide this cycle's winner from the rules, record what the DUT must show, then advance.
  task automatic model_step();
    exp_t e;
    int   g;
    bit   leave;
    g = -1;
    if (!rst) begin
      if (!m_locked) begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (m_ptr + k) % NR;
          if (g < 0 && req_valid[i]) g = i;
        end
      end else if (req_valid[m_owner]) begin
        g = m_owner;
      end
    end
    e.ready = (g >= 0) ? (NR'(1) << g) : '0;
    e.q     = m_q;
    e.owner = m_owner;
    e.busy  = m_locked;
    if (m_known) sb_q.push_back(e);
    if (rst) begin
      m_q = '0; m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_cnt = 0; m_known = 1'b1;
      return;
    end
    if (g >= 0) begin
      for (int b = 0; b < W; b++) begin
        if (req_mask[W*g + b]) begin
          case ({req_jk[2*g+1], req_jk[2*g]})
            2'b01:   m_q[b] = 1'b0;
            2'b10:   m_q[b] = 1'b1;
            2'b11:   m_q[b] = ~m_q[b];
            default: m_q[b] = m_q[b];
          endcase
        end
      end
    end
    if (m_locked) begin
      leave = ((g >= 0) && !req_lock[m_owner]) || (m_cnt == LM - 1);
      m_cnt++;
      if (leave) m_locked = 1'b0;
    end else if (g >= 0) begin
      m_ptr   = (g + 1) % NR;
      m_owner = g;
      if (req_lock[g]) begin
        m_locked = 1'b1;
        m_cnt    = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [NR-1:0] v, input logic [2*NR-1:0] jk,
                       input logic [W*NR-1:0] m, input logic [NR-1:0] l);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_jk    = jk;
    req_mask  = m;
    req_lock  = l;
    model_step();
  endtask

  // Monitor: compare the DUT's visible outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ready", 64'(req_ready), 64'(e.ready));
        check("q",     64'(q),         64'(e.q));
        check("owner", 64'(owner),     64'(e.owner));
        check("busy",  64'(busy),      64'(e.busy));
      end
    end
  end

  initial begin
    int busy_cycles;
    rst = 1'b1; req_valid = '0; req_jk = '0; req_mask = '0; req_lock = '0;

    // Reset then a single SET
    cycle(1, '0, '0, '0, '0);
    cycle(1, '0, '0, '0, '0);
    cycle(0, 4'b0001, 8'b00_00_00_10, 32'h0000_000F, '0);
    cycle(0, '0, '0, '0, '0);
    check("set_q", 64'(q), 64'h0F);
    check("set_owner", 64'(owner), 64'd0);

    // Round robin toggling each requester's own bit
    cycle(1, '0, '0, '0, '0);
    repeat (4) cycle(0, 4'hF, 8'hFF, 32'h0804_0201, '0);
    cycle(0, '0, '0, '0, '0);
    check("rr4_q", 64'(q), 64'h0F);
    repeat (4) cycle(0, 4'hF, 8'hFF, 32'h0804_0201, '0);
    cycle(0, '0, '0, '0, '0);
    check("rr8_q", 64'(q), 64'h00);

    // Lock hold: move pointer to 2, then requester 2 locks while requester 1 waits
    cycle(0, 4'b0010, '0, '0, '0);
    cycle(0, 4'b0110, 8'b00_10_00_00, 32'h00F0_0000, 4'b0100);
    cycle(0, 4'b0110, 8'b00_01_00_00, 32'h0010_0000, '0);
    #1;
    check("lock_busy", 64'(busy), 64'd1);
    check("lock_ready", 64'(req_ready), 64'b0100);
    cycle(0, 4'b1010, '0, '0, '0);
    #1;
    check("lock_q", 64'(q), 64'hE0);
    check("lock_release_busy", 64'(busy), 64'd0);
    check("lock_next_grant", 64'(req_ready), 64'b1000);
    cycle(0, '0, '0, '0, '0);

    // Lock timeout: requester 1 locks then goes idle while requester 0 waits
    cycle(0, 4'b0010, 8'b00_00_10_00, 32'h0000_0100, 4'b0010);
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 4'b0001, 8'b00_00_00_10, 32'h0000_0002, '0);
      if (busy === 1'b1) busy_cycles++;
    end
    check("timeout_busy_cycles", 64'(busy_cycles), 64'(LM));

    // Reset in the second locked cycle
    cycle(0, 4'b0010, 8'b00_00_10_00, 32'h0000_FF00, 4'b0010);
    cycle(0, '0, '0, '0, '0);
    cycle(1, '0, '0, '0, '0);
    cycle(0, 4'hF, '0, '0, '0);
    #1;
    check("rstlock_q", 64'(q), 64'h00);
    check("rstlock_busy", 64'(busy), 64'd0);
    check("rstlock_ready", 64'(req_ready), 64'b0001);
    cycle(0, '0, '0, '0, '0);

`ifdef JK_BANK_ARBITER_STATS_EN
    cycle(1, '0, '0, '0, '0);
    repeat (10) cycle(0, 4'b0111, '0, '0, '0);
    cycle(0, '0, '0, '0, '0);
    check("stall_cnt", 64'(stall_cnt), 64'd10);
`endif

    // Random traffic
    repeat (400) begin
      cycle($urandom_range(0, 59) == 0, NR'($urandom), (2*NR)'($urandom),
            (W*NR)'($urandom), NR'($urandom & $urandom));
    end
    cycle(0, '0, '0, '0, '0);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit bank of JK flip-flop state between NUM_REQ requesters.
- Each requester issues a JK command (hold/clear/set/toggle) with a per-bit mask over a valid/ready handshake.
- At most one command is applied per cycle.
- A requester may lock the bank for a multi-cycle command burst; a lock timeout prevents starvation.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 1..16.
- WIDTH, 8: JK bank width in bits.
- LOCK_MAX, 16: maximum consecutive cycles in LOCKED before a forced release; legal range >=1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  bit i: requester i presents a command.
- req_jk  in  2*NUM_REQ  bits [2i+1:2i]: command of requester i, ordered {j,k}.
- req_mask  in  WIDTH*NUM_REQ  bits [WIDTH*i +: WIDTH]: bits of the bank affected by requester i.
- req_lock  in  NUM_REQ  bit i: keep ownership after this transfer.
- req_ready  out  NUM_REQ  one-hot or zero; grant to requester i.
- q  out  WIDTH  JK bank state.
- owner  out  max(1,$clog2(NUM_REQ))  index of the last granted requester.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (rst=1 at the clock edge): q=0, rr_ptr=0, owner=0, state=IDLE, lock_cnt=0, busy=0.
- req_ready is combinational from state, rr_ptr and req_valid. It is 0 during any cycle where rst=1.
- Transfer to requester i occurs when req_valid[i] & req_ready[i].
- Commands (per bit b, applied only where the mask bit is 1; bits with mask 0 hold):
  - 00 HOLD: q[b] unchanged.
  - 01 CLR: q[b] <= 0.
  - 10 SET: q[b] <= 1.
  - 11 TGL: q[b] <= ~q[b].
- Latency: q shows the result at the clock edge that ends the transfer cycle, i.e. it is visible one cycle after the transfer.
- State IDLE:
  - Grant the first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On transfer: rr_ptr <= i+1 mod NUM_REQ; owner <= i.
  - If req_lock[i]=1 on the transfer: go to LOCKED and set lock_cnt=0.
  - With no valid requester: req_ready=0 and nothing changes.
- State LOCKED:
  - req_ready[owner] = req_valid[owner]. All other requesters stall with ready=0 even if valid.
  - lock_cnt increments every cycle, with or without a transfer.
  - Exit to IDLE on an owner transfer with req_lock[owner]=0. That final command is applied.
  - Forced exit: when lock_cnt reaches LOCK_MAX-1, the current cycle is still granted to the owner; the next state is IDLE regardless of req_lock.
  - rr_ptr is not advanced in LOCKED. It already points past the owner from the entry transfer.
  - owner idle (valid=0) in LOCKED: no transfer; the lock persists until timeout.
- Simultaneous requests: exactly one grant per cycle, and never two ready bits high.
- NUM_REQ=1: rr_ptr stays 0; the lock logic still applies.
- Reset while LOCKED: returns to IDLE and clears q, so in-flight commands are lost.
- Width rules:
  - lock_cnt width is $clog2(LOCK_MAX+1).
  - rr_ptr wraps explicitly; it does not rely on a power-of-two NUM_REQ.

Optional Feature:
- JK_BANK_ARBITER_STATS_EN defined:
  - Adds output stall_cnt (16 bits).
  - stall_cnt increments each cycle in which at least one requester has valid=1 but receives no transfer.
  - It saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package jk_bank_pkg:
  - enum jk_cmd_t {JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11}.
  - enum arb_state_t {ST_IDLE, ST_LOCKED}.
  - Function jk_apply(q, cmd, mask) returning the next bank value.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and index.
  - Reused by the IDLE path.

Test Plan:
- Reset and set:
  - Stimulus: rst for 2 cycles; requester 0 sends SET, mask 8'h0F, lock=0.
  - Response: q=8'h00 during reset; q=8'h0F one cycle after the transfer; owner=0.
- Round robin:
  - Stimulus: requesters 0-3 all valid continuously, each sending TGL on its own bit i, lock=0.
  - Response: grants in order 0,1,2,3,0. After 4 transfers q=8'h0F; after 8 transfers q=8'h00.
- Lock hold:
  - Stimulus: requester 2 transfers SET mask 8'hF0 with lock=1, then CLR mask 8'h10 with lock=0, while requester 1 is valid throughout.
  - Response: requester 1 has ready=0 and busy=1 until the release. q=8'hF0, then 8'hE0. The next grant goes to requester 3 if valid, else requester 1.
- Lock timeout:
  - Stimulus: LOCK_MAX=4; requester 1 locks, then drops valid; requester 0 is valid.
  - Response: busy high for exactly 4 cycles, then requester 0 is granted in IDLE.
- Reset mid-lock:
  - Stimulus: assert rst in the second LOCKED cycle.
  - Response: next cycle q=0, busy=0, rr_ptr=0, so requester 0 wins a full contention.
- Stats (JK_BANK_ARBITER_STATS_EN defined):
  - Stimulus: 3 requesters valid for 10 cycles, no locks.
  - Response: stall_cnt=10.
